// File: rtl/cpu7_ifu_fetchq_pkg.sv
// Shared fetch-unit constants and the fetch-queue entry layout {pc, inst, ex}.
package cpu7_ifu_fetchq_pkg;
    localparam int IFU_INST_W = 32;
    localparam int IFU_PC_W   = 32;
    localparam int IFU_PC_INC = 4;

    // Field order is fixed; the top rebuilds the same layout at its own AW/IW.
    typedef struct packed {
        logic [IFU_PC_W-1:0]   pc;
        logic [IFU_INST_W-1:0] inst;
        logic                  ex;
    } ifu_fq_entry_t;

    function automatic int ifu_fq_entry_w(input int aw, input int iw);
        return aw + iw + 1;
    endfunction
endpackage

// File: rtl/cpu7_ifu_fq_buf.sv
// Generic synchronous FIFO with flush; serves both the instruction queue and the in-flight PC tags.
module cpu7_ifu_fq_buf #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, do_push, do_pop;

    // Explicit wrap so non-power-of-2 depths (tag FIFO) work too.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign cnt     = cnt_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

    no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !do_pop));
endmodule

// File: rtl/cpu7_ifu_fetchq.sv
// Fetch PC generation, credit-limited in-order requests and the decode-side instruction queue.
// Define CPU7_IFU_FETCHQ_BYPASS_EN to present a response on an empty queue in the same cycle.
module cpu7_ifu_fetchq
    import cpu7_ifu_fetchq_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_OUTST = 2,
    parameter int AW        = IFU_PC_W,
    parameter int IW        = IFU_INST_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [AW-1:0]          pc_init,
    output logic                   inst_req,
    output logic [AW-1:0]          inst_addr,
    input  logic                   inst_ack,
    output logic                   inst_cancel,
    input  logic                   inst_valid_f,
    input  logic [IW-1:0]          inst_rdata_f,
    input  logic                   inst_ex,
    input  logic                   redirect_vld,
    input  logic [AW-1:0]          redirect_pc,
    output logic                   fq_dec_vld,
    output logic [AW-1:0]          fq_dec_pc,
    output logic [IW-1:0]          fq_dec_inst,
    output logic                   fq_dec_ex,
    input  logic                   dec_fq_pop,
    output logic [$clog2(DEPTH):0] fq_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;
    localparam int TW = $clog2(MAX_OUTST) + 1;
    localparam int EW = ifu_fq_entry_w(AW, IW);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
        logic          ex;
    } entry_t;

    logic [AW-1:0] pc_bf_q, pc_bf_d;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d;
    logic [SW-1:0] credit_sum;
    logic          acc, rsp_keep, byp, fq_push, fq_pop, fq_empty;
    logic [AW-1:0] tag_pc;
    logic [TW-1:0] tag_cnt;
    logic          tag_empty;
    entry_t        rsp_ent, head_ent, dec_ent;

    // Requests only go out when a queue slot is already reserved for their response.
    assign credit_sum  = SW'(fq_cnt) + SW'(outst_q);
    assign inst_req    = ~reset & ~redirect_vld & (outst_q < CW'(MAX_OUTST)) & (credit_sum < SW'(DEPTH));
    assign inst_addr   = pc_bf_q;
    assign inst_cancel = ~reset & redirect_vld;
    assign acc         = inst_req & inst_ack;
    assign rsp_keep    = ~reset & inst_valid_f & ~redirect_vld & (drop_q == '0);
    assign rsp_ent     = {tag_pc, inst_rdata_f, inst_ex};

`ifdef CPU7_IFU_FETCHQ_BYPASS_EN
    assign byp = rsp_keep & fq_empty;
`else
    assign byp = 1'b0;
`endif

    assign dec_ent     = byp ? rsp_ent : head_ent;
    assign fq_dec_vld  = ~fq_empty | byp;
    assign fq_dec_pc   = dec_ent.pc;
    assign fq_dec_inst = dec_ent.inst;
    assign fq_dec_ex   = dec_ent.ex;
    assign fq_push     = rsp_keep & ~(byp & dec_fq_pop);
    assign fq_pop      = dec_fq_pop & ~fq_empty;

    cpu7_ifu_fq_buf #(.DEPTH(DEPTH), .W(EW)) u_inst_q (
        .clk   (clk),
        .reset (reset),
        .push  (fq_push),
        .pop   (fq_pop),
        .flush (redirect_vld),
        .din   (rsp_ent),
        .dout  (head_ent),
        .cnt   (fq_cnt),
        .empty (fq_empty)
    );

    cpu7_ifu_fq_buf #(.DEPTH(MAX_OUTST), .W(AW)) u_tag_q (
        .clk   (clk),
        .reset (reset),
        .push  (acc),
        .pop   (inst_valid_f & ~reset),
        .flush (1'b0),
        .din   (pc_bf_q),
        .dout  (tag_pc),
        .cnt   (tag_cnt),
        .empty (tag_empty)
    );

    always_comb begin
        pc_bf_d = pc_bf_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        if (redirect_vld)  pc_bf_d = redirect_pc;
        else if (acc)      pc_bf_d = pc_bf_q + AW'(IFU_PC_INC);
        case ({acc, inst_valid_f})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase
        // Everything still in flight at a redirect is stale, including earlier stale ones.
        if (redirect_vld)                        drop_d = outst_q - (inst_valid_f ? CW'(1) : CW'(0));
        else if (inst_valid_f && drop_q != '0)   drop_d = drop_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_bf_q <= pc_init;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_bf_q <= pc_bf_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    tag_tracks_outst: assert property (@(posedge clk) disable iff (reset) CW'(tag_cnt) == outst_q);
    rsp_has_tag:      assert property (@(posedge clk) disable iff (reset) inst_valid_f |-> !tag_empty);
endmodule

// File: tb/tb_cpu7_ifu_fetchq.sv
// Bench for cpu7_ifu_fetchq: queue-based fetch model checked every cycle plus directed scenarios.
module tb_cpu7_ifu_fetchq;
    localparam int DEPTH = 4, MAX_OUTST = 2, AW = 32, IW = 32;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PC_INIT = 32'h1c000000;
    localparam logic [AW-1:0] EX_PC   = 32'h1c000008;

    logic          clk = 1'b0, reset = 1'b1;
    logic [AW-1:0] pc_init = PC_INIT;
    logic          inst_req, inst_ack = 1'b0, inst_cancel;
    logic [AW-1:0] inst_addr;
    logic          inst_valid_f = 1'b0, inst_ex = 1'b0;
    logic [IW-1:0] inst_rdata_f = '0;
    logic          redirect_vld = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          fq_dec_vld, fq_dec_ex, dec_fq_pop = 1'b0;
    logic [AW-1:0] fq_dec_pc;
    logic [IW-1:0] fq_dec_inst;
    logic [CW-1:0] fq_cnt;

    always #5 clk = ~clk;

    cpu7_ifu_fetchq #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .AW(AW), .IW(IW)) dut (
        .clk(clk), .reset(reset), .pc_init(pc_init),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_cancel(inst_cancel),
        .inst_valid_f(inst_valid_f), .inst_rdata_f(inst_rdata_f), .inst_ex(inst_ex),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .fq_dec_vld(fq_dec_vld), .fq_dec_pc(fq_dec_pc), .fq_dec_inst(fq_dec_inst),
        .fq_dec_ex(fq_dec_ex), .dec_fq_pop(dec_fq_pop), .fq_cnt(fq_cnt)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [AW-1:0] at(input logic [AW-1:0] q[$], input int i);
        return (i < q.size()) ? q[i] : '1;
    endfunction

    // Model: in-flight list with a stale mark per request, and the queue as a plain list.
    typedef struct { logic [AW-1:0] pc; bit stale; } inf_t;
    typedef struct { logic [AW-1:0] pc; logic [IW-1:0] inst; logic ex; } ent_t;
    inf_t          m_inf[$];
    ent_t          m_fq[$];
    logic [AW-1:0] m_pc = PC_INIT;
    logic [AW-1:0] pending[$];
    logic [AW-1:0] pop_log[$];
    logic [AW-1:0] ex_log[$];

    always @(negedge clk) begin
        bit   exp_req, keep, byp, exp_vld, popped;
        ent_t head;
        inf_t f;
        head = '{'0, '0, 1'b0};
        if (reset) begin
            m_pc = pc_init;
            m_inf.delete();
            m_fq.delete();
        end
        exp_req = !reset && !redirect_vld && (m_inf.size() < MAX_OUTST) &&
                  (m_fq.size() + m_inf.size() < DEPTH);
        keep = !reset && inst_valid_f && !redirect_vld && (m_inf.size() > 0) && !m_inf[0].stale;
        byp = 1'b0;
`ifdef CPU7_IFU_FETCHQ_BYPASS_EN
        byp = keep && (m_fq.size() == 0);
`endif
        exp_vld = (m_fq.size() > 0) || byp;
        if (byp)                    head = '{m_inf[0].pc, inst_rdata_f, inst_ex};
        else if (m_fq.size() > 0)   head = m_fq[0];

        chk("inst_req", inst_req, exp_req);
        chk("inst_addr", inst_addr, m_pc);
        chk("inst_cancel", inst_cancel, !reset && redirect_vld);
        chk("fq_dec_vld", fq_dec_vld, exp_vld);
        chk("fq_cnt", fq_cnt, m_fq.size());
        if (exp_vld) begin
            chk("fq_dec_pc", fq_dec_pc, head.pc);
            chk("fq_dec_inst", fq_dec_inst, head.inst);
            chk("fq_dec_inst_mem", fq_dec_inst, mem_data(head.pc));
            chk("fq_dec_ex", fq_dec_ex, head.ex);
        end

        if (!reset) begin
            popped = dec_fq_pop && exp_vld;
            if (popped) begin
                pop_log.push_back(head.pc);
                if (head.ex) ex_log.push_back(head.pc);
                if (!byp) m_fq.delete(0);
            end
            if (inst_valid_f && m_inf.size() > 0) begin
                f = m_inf[0];
                m_inf.delete(0);
                if (keep && !(byp && dec_fq_pop)) m_fq.push_back('{f.pc, inst_rdata_f, inst_ex});
            end
            if (redirect_vld) begin
                m_fq.delete();
                foreach (m_inf[i]) m_inf[i].stale = 1'b1;
                m_pc = redirect_pc;
            end
            if (exp_req && inst_ack) begin
                m_inf.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        if (inst_req && inst_ack) pending.push_back(inst_addr);
        chk("outst_bound", pending.size() <= MAX_OUTST, 1'b1);
    end

    // Memory stub answers the oldest accepted request one cycle (or more) later.
    task automatic cyc(input bit ack, input bit pop, input bit rsp,
                       input bit rdr = 1'b0, input logic [AW-1:0] rpc = '0);
        logic [AW-1:0] a;
        @(posedge clk); #1;
        inst_ack     = ack;
        dec_fq_pop   = pop;
        redirect_vld = rdr;
        redirect_pc  = rpc;
        if (!reset && rsp && pending.size() > 0) begin
            a            = pending.pop_front();
            inst_valid_f = 1'b1;
            inst_rdata_f = mem_data(a);
            inst_ex      = (a == EX_PC);
        end else begin
            inst_valid_f = 1'b0;
            inst_rdata_f = '0;
            inst_ex      = 1'b0;
        end
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    initial begin
        int n;
        repeat (2) cyc(0, 0, 0);
        sample();
        chk("reset_inst_req", inst_req, 1'b0);
        chk("reset_fq_vld", fq_dec_vld, 1'b0);
        chk("reset_fq_cnt", fq_cnt, 0);
        chk("reset_inst_addr", inst_addr, PC_INIT);
        @(posedge clk); #1; reset = 1'b0;

        // Streaming with an exception on 0x1c000008
        pop_log.delete(); ex_log.delete();
        repeat (16) cyc(1, 1, 1);
        sample();
        chk("stream_pc0", at(pop_log, 0), 32'h1c000000);
        chk("stream_pc1", at(pop_log, 1), 32'h1c000004);
        chk("stream_pc5", at(pop_log, 5), 32'h1c000014);
        chk("stream_pops", pop_log.size() >= 12, 1'b1);
        chk("ex_count", ex_log.size(), 1);
        chk("ex_pc", at(ex_log, 0), EX_PC);

        // Backpressure: decode stalls, queue fills to DEPTH, then resumes
        repeat (8) cyc(1, 0, 1);
        sample();
        chk("bp_fq_cnt", fq_cnt, 4);
        chk("bp_inst_req", inst_req, 1'b0);
        pop_log.delete();
        repeat (10) cyc(1, 1, 1);
        sample();
        chk("bp_order", at(pop_log, 1) - at(pop_log, 0), 4);

        // Redirect with two requests in flight
        repeat (3) cyc(1, 1, 0);
        cyc(1, 1, 0, 1'b1, 32'h1c000100);
        sample();
        chk("rdr_cancel", inst_cancel, 1'b1);
        chk("rdr_inst_req", inst_req, 1'b0);
        chk("rdr_in_flight", pending.size(), 2);
        pop_log.delete();
        cyc(1, 1, 1);
        sample();
        chk("rdr_flushed", fq_cnt, 0);
        chk("rdr_no_cancel", inst_cancel, 1'b0);
        repeat (8) cyc(1, 1, 1);
        sample();
        chk("rdr_first_pc", at(pop_log, 0), 32'h1c000100);
        chk("rdr_second_pc", at(pop_log, 1), 32'h1c000104);

        // Redirect with a coincident response, then a second redirect while one is still stale
        repeat (3) cyc(1, 1, 0);
        cyc(1, 1, 1, 1'b1, 32'h1c000200);
        sample();
        chk("rdr2_cancel", inst_cancel, 1'b1);
        cyc(1, 1, 0);
        sample();
        chk("rdr2_req", inst_req, 1'b1);
        chk("rdr2_addr", inst_addr, 32'h1c000200);
        cyc(1, 1, 0, 1'b1, 32'h1c000300);
        sample();
        pop_log.delete();
        repeat (10) cyc(1, 1, 1);
        sample();
        chk("rdr3_first_pc", at(pop_log, 0), 32'h1c000300);
        n = 0;
        foreach (pop_log[i]) if (pop_log[i][31:8] == 24'h1c0002) n++;
        chk("rdr3_no_stale", n, 0);

        // Reset mid-stream with two outstanding
        repeat (3) cyc(1, 0, 0);
        sample();
        chk("pre_rst_in_flight", pending.size(), 2);
        chk("pre_rst_fq_busy", fq_cnt != 0, 1'b1);
        #2;
        reset = 1'b1;
        pending.delete();
        inst_valid_f = 1'b0;
        #1;
        chk("arst_inst_req", inst_req, 1'b0);
        chk("arst_fq_vld", fq_dec_vld, 1'b0);
        chk("arst_fq_cnt", fq_cnt, 0);
        chk("arst_inst_addr", inst_addr, PC_INIT);
        repeat (2) cyc(0, 0, 0);
        @(posedge clk); #1; reset = 1'b0;
        pop_log.delete();
        repeat (10) cyc(1, 1, 1);
        sample();
        chk("post_rst_first_pc", at(pop_log, 0), PC_INIT);
        chk("post_rst_second_pc", at(pop_log, 1), 32'h1c000004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu7_ifu_fetchq.md
Name: cpu7_ifu_fetchq

Overview:
Parametrised next-generation fetch datapath. Generates the fetch PC, keeps up to MAX_OUTST pipelined in-order instruction requests in flight, and buffers returned instructions in a DEPTH-entry FIFO ahead of decode. On a redirect (branch, exception or ertn, merged upstream) it flushes the FIFO and silently discards stale in-flight responses, so decode never sees wrong-path instructions.

Parameters:
DEPTH, 4, fetch-queue entries (power of 2, >=2)
MAX_OUTST, 2, max accepted-but-unanswered requests (1..DEPTH)
AW, 32, PC/address width
IW, 32, instruction width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
pc_init  in  AW  PC loaded at reset
inst_req  out  1  fetch request valid
inst_addr  out  AW  fetch address, word aligned
inst_ack  in  1  address accepted this cycle (with inst_req)
inst_cancel  out  1  one-cycle pulse on redirect
inst_valid_f  in  1  response valid (in request order)
inst_rdata_f  in  IW  response data
inst_ex  in  1  response carries a fetch exception
redirect_vld  in  1  redirect fetch
redirect_pc  in  AW  redirect target
fq_dec_vld  out  1  head entry valid
fq_dec_pc  out  AW  head PC
fq_dec_inst  out  IW  head instruction
fq_dec_ex  out  1  head exception flag
dec_fq_pop  in  1  decode consumes head (ignored when fq_dec_vld=0)
fq_cnt  out  $clog2(DEPTH)+1  occupancy (debug)

Behaviour:
- Reset (async): pc_bf=pc_init, FIFO empty, outst=0, drop_cnt=0; inst_req=0 while reset is high; fq_dec_vld=0; inst_cancel=0.
- Credit: inst_req = ~reset & ~redirect_vld & (outst < MAX_OUTST) & (fq_cnt + outst < DEPTH). Every accepted request is therefore guaranteed a slot, and there is no backpressure on responses.
- inst_addr = pc_bf. On inst_req & inst_ack: pc_bf += 4 (wraps modulo 2^AW), outst++, and the request PC is pushed into a MAX_OUTST-entry in-flight PC tag FIFO.
- Response with drop_cnt == 0: the tag is popped, and {tag PC, data, inst_ex} is written to the FIFO tail. outst-- (net 0 if a request is accepted in the same cycle).
- Response with drop_cnt > 0: discarded; drop_cnt--, outst--, tag popped.
- Redirect (redirect_vld=1 in cycle T):
  - pc_bf is set to redirect_pc at T+1.
  - FIFO cleared.
  - inst_cancel=1 combinationally in T.
  - drop_cnt = outst - (response in T ? 1 : 0). A response in T is discarded.
  - No request is issued in T.
  - A pop in T is honoured, because decode has already consumed the head.
- Redirect while drop_cnt > 0: drop_cnt is recomputed by the same rule, so it accumulates all stale responses.
- FIFO: push and pop in the same cycle are both allowed at any occupancy, with fq_cnt unchanged. A push when full cannot occur (guaranteed by the credit rule); the assertion fires if it does. Pointers wrap modulo DEPTH.
- Latency: a response written in cycle T is visible on fq_dec_* at T+1.
- inst_ex entries are enqueued as normal. The fetch unit does not stop itself; upstream redirect handles exceptions.

Optional Feature:
CPU7_IFU_FETCHQ_BYPASS_EN.
- Defined: when the FIFO is empty and a non-dropped response arrives, fq_dec_* presents it combinationally in the same cycle.
  - If dec_fq_pop is asserted that cycle, the response is not written.
  - Otherwise it is written to the FIFO normally.
- Undefined: no bypass; fixed 1-cycle latency.

Decomposition:
- Shared package (cpu7 common header): IFU_INST_W, IFU_PC_INC=4, and the fetch-queue entry layout {pc, inst, ex} as a typedef or field macros.
- One natural sub-module: cpu7_ifu_fq_buf. It is a generic parametrised synchronous FIFO (DEPTH, width) with push, pop, flush, cnt, head output and async active-high reset. It is instantiated twice: once for the instruction queue and once for the in-flight PC tags.

Test Plan:
- Streaming: pc_init=0x1c000000, inst_ack always 1, response 1 cycle after accept, pop every cycle -> fq_dec_pc = 0x1c000000, 0x1c000004, ... back-to-back, outst never exceeds 2.
- Backpressure: DEPTH=4, MAX_OUTST=2, pop held 0 -> inst_req drops once fq_cnt+outst=4; fq_cnt settles at 4 with no overflow. Pop resumes -> ordering intact.
- Redirect with 2 in flight: redirect_pc=0x1c000100 -> inst_cancel pulse, FIFO empty next cycle, next 2 responses dropped, first visible head PC = 0x1c000100.
- Redirect coinciding with a response and a second redirect while drop_cnt=1 -> all stale responses dropped, only the last target is fetched.
- inst_ex=1 on the response for 0x1c000008 -> fq_dec_ex=1 on exactly that entry.
- Reset asserted mid-stream with 2 outstanding -> outputs clear asynchronously, inst_req=0. After release, fetch restarts at pc_init.
